// File: rtl/ucode_sequencer_if.sv
// Bus bundle for ucode_sequencer: IR/stall inputs, microcode write port and control outputs.
// master drives instruction and table writes; slave is the sequencer.
interface ucode_sequencer_if #(
  parameter int unsigned IW   = 8,
  parameter int unsigned CW_W = 13,
  parameter int unsigned SW   = 4,
  parameter int unsigned NOPS = 16
);
  localparam int unsigned OW = $clog2(NOPS);
  localparam int unsigned AW = OW + SW;

  logic [IW-1:0]   instr;
  logic            stall;
  logic            ucode_we;
  logic [AW-1:0]   ucode_addr;
  logic [CW_W:0]   ucode_wdata;
  logic [CW_W-1:0] cw;
  logic [SW-1:0]   step;
  logic            fetch;
  logic            illegal;

  modport master (
    output instr, stall, ucode_we, ucode_addr, ucode_wdata,
    input  cw, step, fetch, illegal
  );

  modport slave (
    input  instr, stall, ucode_we, ucode_addr, ucode_wdata,
    output cw, step, fetch, illegal
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Microcoded control sequencer with writable {opcode, step} table, updated on the falling clock edge.
// Optional macro UCODE_OVERRUN_TRAP_EN: a step overrun ends the instruction and sets illegal.
module ucode_sequencer #(
  parameter int unsigned IW   = 8,
  parameter int unsigned CW_W = 13,
  parameter int unsigned SW   = 4,
  parameter int unsigned NOPS = 16
) (
  input logic             clk,
  input logic             rst_n,
  ucode_sequencer_if.slave bus
);
  localparam int unsigned OW    = $clog2(NOPS);
  localparam int unsigned AW    = OW + SW;
  localparam int unsigned Depth = 2 ** AW;

  logic [CW_W:0]   mem_q [Depth];
  logic [CW_W-1:0] cw_q, cw_d;
  logic [SW-1:0]   step_q, step_d;
  logic            fetch_q, fetch_d;
  logic            illegal_q, illegal_d;

  logic [AW-1:0]   rd_addr;
  logic [CW_W:0]   entry;
  logic            legal;
  logic            last;

  assign rd_addr = {bus.instr[OW-1:0], step_q};
  assign entry   = mem_q[rd_addr];
  assign last    = entry[CW_W];
  assign legal   = ({1'b0, bus.instr} < (IW + 1)'(NOPS));

  // Table RAM has no reset; a same-edge read still sees the old entry.
  always_ff @(negedge clk) begin
    if (bus.ucode_we) begin
      mem_q[bus.ucode_addr] <= bus.ucode_wdata;
    end
  end

  always_comb begin
    cw_d      = cw_q;
    step_d    = step_q;
    fetch_d   = fetch_q;
    illegal_d = illegal_q;
    if (bus.stall) begin
      cw_d    = '0;
      fetch_d = 1'b0;
    end else if (!legal) begin
      cw_d      = '0;
      fetch_d   = 1'b1;
      step_d    = '0;
      illegal_d = 1'b1;
    end else if (last) begin
      cw_d    = entry[CW_W-1:0];
      fetch_d = 1'b1;
      step_d  = '0;
    end else if (step_q == '1) begin
      cw_d   = entry[CW_W-1:0];
      step_d = '0;
`ifdef UCODE_OVERRUN_TRAP_EN
      fetch_d   = 1'b1;
      illegal_d = 1'b1;
`else
      fetch_d = 1'b0;
`endif
    end else begin
      cw_d    = entry[CW_W-1:0];
      fetch_d = 1'b0;
      step_d  = step_q + 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_q      <= '0;
      step_q    <= '0;
      fetch_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      cw_q      <= cw_d;
      step_q    <= step_d;
      fetch_q   <= fetch_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.cw      = cw_q;
  assign bus.step    = step_q;
  assign bus.fetch   = fetch_q;
  assign bus.illegal = illegal_q;
endmodule
